// File: rtl/queued_emitter_pkg.sv
// Shared types and sizing helpers for the queued serial emitter.
// Imported by the FIFO, the link interface and the top.
package queued_emitter_pkg;

  localparam int LINK_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic int ptr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/queued_emitter_if.sv
// Producer-side write port and serial link of the queued emitter.
// master = producer/observer, slave = emitter.
interface queued_emitter_if
  import queued_emitter_pkg::*;
#(
  parameter int W = LINK_W
) ();

  logic [W-1:0] wr_data;
  logic         wr_en;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         serial_out;
  logic         serial_done;
  logic         busy;
  logic [15:0]  frames_sent;

  modport master (
    output wr_data, wr_en,
    input  full, empty, overflow,
    input  serial_out, serial_done,
    input  busy, frames_sent
  );

  modport slave (
    input  wr_data, wr_en,
    output full, empty, overflow,
    output serial_out, serial_done,
    output busy, frames_sent
  );

endinterface

// File: rtl/queued_emitter_fifo.sv
// Synchronous fall-through FIFO feeding the serializer.
// Head word is visible on rd_data whenever the FIFO is non-empty.
module emitter_fifo
  import queued_emitter_pkg::*;
#(
  parameter int W     = LINK_W,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/queued_emitter.sv
// Buffered LSB-first serial transmitter with done-pulse framing.
// FIFO-fed FSM: IDLE -> SHIFT -> DONE -> (GAP) -> SHIFT/IDLE.
module queued_emitter
  import queued_emitter_pkg::*;
#(
  parameter int OUTPUT_WIDTH = LINK_W,
  parameter int DEPTH        = 4,
  parameter int GAP          = 0
) (
  input  logic             fast_clk,
  input  logic             reset,
  queued_emitter_if.slave  link
);

  localparam int BW = (OUTPUT_WIDTH > 1) ?
                      $clog2(OUTPUT_WIDTH) : 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(OUTPUT_WIDTH - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP > 0) ? GAP - 1 : 0);

  state_t                  state;
  state_t                  state_nx;
  logic [OUTPUT_WIDTH-1:0] shreg;
  logic [OUTPUT_WIDTH-1:0] head;
  logic [BW-1:0]           bit_cnt;
  logic [3:0]              gap_cnt;
  logic [15:0]             frames_sent;
  logic                    overflow;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic                    has_word;
  logic                    pop;
  logic                    serial_out;
  logic                    serial_done;

  emitter_fifo #(
    .W     (OUTPUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (fast_clk),
    .rst_n   (reset),
    .wr_data (link.wr_data),
    .wr_en   (link.wr_en),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign has_word = |count;
  // A pop happens on every entry into SHIFT.
  assign pop = (state_nx == ST_SHIFT) &&
               (state != ST_SHIFT);

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (has_word) state_nx = ST_SHIFT;
      ST_SHIFT:
        if (bit_cnt == LAST_BIT) state_nx = ST_DONE;
      ST_DONE:
        if (GAP > 0)       state_nx = ST_GAP;
        else if (has_word) state_nx = ST_SHIFT;
        else               state_nx = ST_IDLE;
      ST_GAP:
        if (gap_cnt == GAP_LAST)
          state_nx = has_word ? ST_SHIFT : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    serial_out  = 1'b0;
    serial_done = 1'b0;
    unique case (state)
      ST_SHIFT: serial_out  = shreg[0];
      ST_DONE:  serial_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pop) begin
        shreg   <= head;
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ?
                 gap_cnt + 1'b1 : '0;
      if (state == ST_DONE)
        frames_sent <= frames_sent + 1'b1;
      if (link.wr_en && full) overflow <= 1'b1;
    end
  end

  assign link.full        = full;
  assign link.empty       = empty;
  assign link.overflow    = overflow;
  assign link.serial_out  = serial_out;
  assign link.serial_done = serial_done;
  assign link.busy        = state != ST_IDLE;
  assign link.frames_sent = frames_sent;

endmodule

// File: tb/tb_queued_emitter.sv
// Scoreboard bench for queued_emitter: a collector-style monitor
// rebuilds each frame and compares it against queued expectations.
module tb_queued_emitter;
  import queued_emitter_pkg::*;

  localparam int W = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  queued_emitter_if #(.W(W)) if0 ();
  queued_emitter_if #(.W(W)) if3 ();

  queued_emitter #(
    .OUTPUT_WIDTH (W),
    .DEPTH        (4),
    .GAP          (0)
  ) dut0 (
    .fast_clk (clk),
    .reset    (rst_n),
    .link     (if0)
  );

  queued_emitter #(
    .OUTPUT_WIDTH (W),
    .DEPTH        (4),
    .GAP          (3)
  ) dut3 (
    .fast_clk (clk),
    .reset    (rst_n),
    .link     (if3)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q3[$];
  int           d0[$];
  int           d3[$];
  logic [W-1:0] col0, col3;
  logic         pd0, pd3;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Collector model for the GAP=0 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      col0 = '0;
      pd0  = 1'b0;
    end else begin
      if (if0.serial_done) begin
        d0.push_back(cyc);
        check("done0_not_back_to_back", 32'(pd0), 0);
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done0_unexpected: got %0h expected none",
                   col0);
        end else begin
          check("frame0", 32'(col0), 32'(q0.pop_front()));
        end
      end
      col0 = {if0.serial_out, col0[W-1:1]};
      pd0  = if0.serial_done;
    end
  end

  // Collector model for the GAP=3 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      col3 = '0;
      pd3  = 1'b0;
    end else begin
      if (if3.serial_done) begin
        d3.push_back(cyc);
        check("done3_not_back_to_back", 32'(pd3), 0);
        if (q3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done3_unexpected: got %0h expected none",
                   col3);
        end else begin
          check("frame3", 32'(col3), 32'(q3.pop_front()));
        end
      end
      col3 = {if3.serial_out, col3[W-1:1]};
      pd3  = if3.serial_done;
    end
  end

  task automatic wr0(logic [W-1:0] w, bit ok);
    if0.wr_data = w;
    if0.wr_en   = 1'b1;
    if (ok) q0.push_back(w);
    @(posedge clk);
    #1;
    if0.wr_en = 1'b0;
  endtask

  task automatic wr3(logic [W-1:0] w);
    if3.wr_data = w;
    if3.wr_en   = 1'b1;
    q3.push_back(w);
    @(posedge clk);
    #1;
    if3.wr_en = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((q0.size() != 0 || q3.size() != 0 ||
            if0.busy || if3.busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q0.size() + q3.size());
    end
  endtask

  function automatic int gap_of(int a[$], int i);
    return (a.size() > i) ? a[i] - a[i-1] : -1;
  endfunction

  int kw;
  int bad;

  initial begin
    if0.wr_en   = 1'b0;
    if0.wr_data = '0;
    if3.wr_en   = 1'b0;
    if3.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and quiet link
    check("rst_full", 32'(if0.full), 0);
    check("rst_empty", 32'(if0.empty), 1);
    check("rst_overflow", 32'(if0.overflow), 0);
    check("rst_frames", 32'(if0.frames_sent), 0);
    check("rst_busy", 32'(if0.busy), 0);
    check("rst_empty3", 32'(if3.empty), 1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (if0.serial_out || if0.serial_done ||
          !if0.empty || if0.busy)
        bad++;
    end
    check("idle50_violations", bad, 0);
    @(posedge clk);
    #1;

    // Single all-ones word, latency check
    wr0(25'h1FF_FFFF, 1'b1);
    kw = cyc;
    drain(200);
    check("latency_done",
          (d0.size() > 0) ? d0[0] - kw : -1, 26);
    check("frames_after_1", 32'(if0.frames_sent), 1);

    // Four back-to-back words
    d0.delete();
    wr0(25'd69420, 1'b1);
    wr0(25'd3461, 1'b1);
    wr0(25'd0, 1'b1);
    wr0(25'd69, 1'b1);
    drain(400);
    check("b2b_count", d0.size(), 4);
    for (int i = 1; i < 4; i++)
      check("b2b_period", gap_of(d0, i), 26);
    check("b2b_overflow", 32'(if0.overflow), 0);
    check("frames_after_5", 32'(if0.frames_sent), 5);

    // Fill behind an in-flight frame, fifth write dropped
    d0.delete();
    wr0(25'h155_5555, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    wr0(25'h000_0001, 1'b1);
    wr0(25'h100_0000, 1'b1);
    wr0(25'h0F0_F0F0, 1'b1);
    wr0(25'h123_4567, 1'b1);
    check("fill_full", 32'(if0.full), 1);
    check("fill_no_ovf_yet", 32'(if0.overflow), 0);
    wr0(25'h0AB_CDEF, 1'b0);
    check("drop_overflow", 32'(if0.overflow), 1);
    check("drop_still_full", 32'(if0.full), 1);
    drain(600);
    check("fill_count", d0.size(), 5);
    for (int i = 2; i < 5; i++)
      check("fill_period", gap_of(d0, i), 26);
    check("ovf_sticky", 32'(if0.overflow), 1);
    check("fill_empty", 32'(if0.empty), 1);
    check("frames_after_10", 32'(if0.frames_sent), 10);

    // GAP=3 spacing
    d3.delete();
    wr3(25'h0C3_A5A5);
    wr3(25'h13C_5A0F);
    drain(300);
    check("gap_count", d3.size(), 2);
    check("gap_period", gap_of(d3, 1), 29);
    check("gap_frames", 32'(if3.frames_sent), 2);

    // Reset mid-frame at bit 10
    d0.delete();
    wr0(25'h0FF_FC00, 1'b1);
    kw = cyc;
    while (cyc < kw + 11) @(negedge clk);
    check("pre_rst_bit10", 32'(if0.serial_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(if0.serial_out), 0);
    check("mid_rst_done", 32'(if0.serial_done), 0);
    check("mid_rst_busy", 32'(if0.busy), 0);
    check("mid_rst_empty", 32'(if0.empty), 1);
    check("mid_rst_frames", 32'(if0.frames_sent), 0);
    check("mid_rst_ovf", 32'(if0.overflow), 0);
    q0.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_no_done", d0.size(), 0);
    wr0(25'h0A5_5A5A, 1'b1);
    drain(200);
    check("post_rst_count", d0.size(), 1);
    check("post_rst_frames", 32'(if0.frames_sent), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
